// File: rtl/usb_pkg.sv
// Shared USB transmit-path definitions: encoder state type and line constants.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } tx_state_e;

    // Idle line level; every packet's NRZI stream is referenced to it.
    localparam logic J_LEVEL = 1'b1;

    localparam int STUFF_LIMIT_DEF = 6;

endpackage

// File: rtl/nrzi_stuff_encoder_if.sv
// Bundle between the transmit serializer, the line encoder and the DPDM driver.
interface nrzi_stuff_encoder_if;

    logic in_bit;
    logic bs_sending;
    logic stall;
    logic out_bit;
    logic nrzi_sending;

    modport master (
        output in_bit,
        output bs_sending,
        input  stall,
        input  out_bit,
        input  nrzi_sending
    );

    modport slave (
        input  in_bit,
        input  bs_sending,
        output stall,
        output out_bit,
        output nrzi_sending
    );

endinterface

// File: rtl/nrzi_stuff_encoder_fsm.sv
// Bit-stuffing sequencer: tracks the run of consecutive 1s and schedules a
// stuffed 0 once the run reaches STUFF_LIMIT.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no packet on the line, line held at J
//   SEND  | consuming raw bits from the serializer
//   STUFF | emitting a stuffed 0, raw bit held upstream via stall
module nrzi_stuff_encoder_fsm
    import usb_pkg::*;
#(
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      in_bit,
    input  logic      bs_sending,
    output tx_state_e state,
    output logic      stall
);

    localparam int CNT_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(STUFF_LIMIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;

    // State and run-length registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ones_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    // Next-state and run-length decode; the counter clears before it can
    // exceed STUFF_LIMIT because reaching it always forces STUFF.
    always_comb begin
        state_d    = state_q;
        ones_cnt_d = '0;
        case (state_q)
            IDLE, SEND: begin
                if (bs_sending) begin
                    ones_cnt_d = in_bit ? ones_cnt_q + CNT_W'(1) : '0;
                    state_d    = (in_bit && ones_cnt_q == RUN_LAST) ? STUFF : SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            STUFF:   state_d = SEND;
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;
    assign stall = (state_q == STUFF);

endmodule

// File: rtl/nrzi_stuff_encoder.sv
// USB transmit line encoder: bit stuffing followed by NRZI (0 toggles, 1 holds).
module nrzi_stuff_encoder
    import usb_pkg::*;
#(
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    nrzi_stuff_encoder_if.slave  bus
);

    tx_state_e state;
    logic      stall;
    logic      out_bit_q, out_bit_d;
    logic      sending_q, sending_d;

    nrzi_stuff_encoder_fsm #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_fsm (
        .clock      (clock),
        .reset      (reset),
        .in_bit     (bus.in_bit),
        .bs_sending (bus.bs_sending),
        .state      (state),
        .stall      (stall)
    );

    // Encode mux: stuffed 0 toggles, consumed bit is NRZI-coded, otherwise J.
    always_comb begin
        out_bit_d = J_LEVEL;
        sending_d = 1'b0;
        if (state == STUFF) begin
            out_bit_d = ~out_bit_q;
            sending_d = 1'b1;
        end else if (bus.bs_sending) begin
            out_bit_d = bus.in_bit ? out_bit_q : ~out_bit_q;
            sending_d = 1'b1;
        end
    end

    // Registered line outputs toward the DPDM driver.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_bit_q <= J_LEVEL;
            sending_q <= 1'b0;
        end else begin
            out_bit_q <= out_bit_d;
            sending_q <= sending_d;
        end
    end

    assign bus.out_bit      = out_bit_q;
    assign bus.nrzi_sending = sending_q;
    assign bus.stall        = stall;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// Randomized and directed bench for nrzi_stuff_encoder against a stream-level
// reference: stuff the raw packet, NRZI it from J, then compare cycle by cycle.
module tb_nrzi_stuff_encoder;

    localparam int LIM = 6;

    typedef bit bitq_t[$];

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    nrzi_stuff_encoder_if bus ();

    nrzi_stuff_encoder #(
        .STUFF_LIMIT (LIM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with bs_sending low; returns at a negedge after
    // `gap` idle cycles with bs_sending still low.
    task automatic run_packet(input bitq_t bits, input int gap);
        bit stf[$];
        bit lvl[$];
        bit cur;
        int ones;
        int idx;
        cur  = 1'b1;
        ones = 0;
        foreach (bits[i]) begin
            cur = bits[i] ? cur : ~cur;
            stf.push_back(1'b0);
            lvl.push_back(cur);
            if (bits[i]) begin
                ones++;
                if (ones == LIM) begin
                    cur = ~cur;
                    stf.push_back(1'b1);
                    lvl.push_back(cur);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        idx = 0;
        for (int k = 0; k < stf.size(); k++) begin
            if (k > 0) begin
                chk("out_bit", bus.out_bit, lvl[k-1]);
                chk("nrzi_sending", bus.nrzi_sending, 1);
            end
            if (idx < bits.size()) begin
                bus.bs_sending = 1'b1;
                bus.in_bit     = bits[idx];
            end else begin
                bus.bs_sending = 1'b0;
            end
            #1;
            chk("stall", bus.stall, stf[k]);
            if (!stf[k]) idx++;
            @(negedge clock);
        end
        chk("out_bit_last", bus.out_bit, lvl[lvl.size()-1]);
        chk("nrzi_sending_last", bus.nrzi_sending, 1);
        bus.bs_sending = 1'b0;
        @(negedge clock);
        for (int g = 0; g < gap; g++) begin
            if (g > 0) @(negedge clock);
            chk("idle_out_bit", bus.out_bit, 1);
            chk("idle_nrzi_sending", bus.nrzi_sending, 0);
            chk("idle_stall", bus.stall, 0);
        end
    endtask

    initial begin
        bitq_t q;
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.bs_sending = 1'b0;
        bus.in_bit     = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_out_bit", bus.out_bit, 1);
        chk("reset_nrzi_sending", bus.nrzi_sending, 0);
        chk("reset_stall", bus.stall, 0);
        reset = 1'b0;
        @(negedge clock);

        q = '{0, 0, 0, 0, 0, 0, 0, 1};
        run_packet(q, 2);
        q = '{1, 1, 1, 1, 1, 1, 0};
        run_packet(q, 1);
        q = '{1, 1, 1, 1, 1, 1};
        run_packet(q, 2);
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(1'b1);
        run_packet(q, 1);
        q = '{1, 0, 1, 1};
        run_packet(q, 1);
        q = '{1, 1, 0};
        run_packet(q, 2);

        // Reset while the stuff bit is being emitted.
        for (int i = 0; i < LIM; i++) begin
            bus.bs_sending = 1'b1;
            bus.in_bit     = 1'b1;
            @(negedge clock);
        end
        chk("pre_reset_stall", bus.stall, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_stuff_reset_out_bit", bus.out_bit, 1);
        chk("mid_stuff_reset_nrzi_sending", bus.nrzi_sending, 0);
        chk("mid_stuff_reset_stall", bus.stall, 0);
        reset          = 1'b0;
        bus.bs_sending = 1'b0;
        @(negedge clock);
        q = '{0};
        run_packet(q, 1);

        for (int p = 0; p < 40; p++) begin
            int len;
            q   = {};
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 3) != 0);
            run_packet(q, $urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
